// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, instruction field positions, tag record
// and decoded register-usage record.
package pipe_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_MOD  = 5'd4;
  localparam logic [4:0] OP_CMP  = 5'd5;
  localparam logic [4:0] OP_AND  = 5'd6;
  localparam logic [4:0] OP_OR   = 5'd7;
  localparam logic [4:0] OP_NOT  = 5'd8;
  localparam logic [4:0] OP_MOV  = 5'd9;
  localparam logic [4:0] OP_LSL  = 5'd10;
  localparam logic [4:0] OP_LSR  = 5'd11;
  localparam logic [4:0] OP_ASR  = 5'd12;
  localparam logic [4:0] OP_NOP  = 5'd13;
  localparam logic [4:0] OP_LD   = 5'd14;
  localparam logic [4:0] OP_ST   = 5'd15;
  localparam logic [4:0] OP_BEQ  = 5'd16;
  localparam logic [4:0] OP_BGT  = 5'd17;
  localparam logic [4:0] OP_B    = 5'd18;
  localparam logic [4:0] OP_CALL = 5'd19;
  localparam logic [4:0] OP_RET  = 5'd20;

  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 27;
  localparam int IMM_BIT = 26;
  localparam int RD_HI   = 25;
  localparam int RD_LO   = 22;
  localparam int RS1_HI  = 21;
  localparam int RS1_LO  = 18;
  localparam int RS2_HI  = 17;
  localparam int RS2_LO  = 14;

  localparam logic [3:0]  RA        = 4'hF;
  localparam logic [31:0] NOP_INSTR = {OP_NOP, 27'd0};

  typedef struct packed {
    logic       valid;
    logic       is_load;
    logic [3:0] rd;
  } tag_t;

  typedef struct packed {
    logic            dst_valid;
    logic [3:0]      dst;
    logic            is_load;
    logic [2:0]      src_valid;
    logic [2:0][3:0] src;
  } usage_t;

endpackage

// File: rtl/instr_reg_usage.sv
// Combinational decode of one instruction into the registers it writes and reads.
// Source slots: 0 = rs1 (or ra for ret), 1 = rs2, 2 = rd read by st.
module instr_reg_usage
  import pipe_pkg::*;
(
  input  logic [31:0] instr_i,
  output usage_t      usage_o
);

  logic [4:0] op;
  logic       imm;
  logic [3:0] rd, rs1, rs2;
  logic       alu3;
  logic       unused_bits;

  assign op          = instr_i[OPC_HI:OPC_LO];
  assign imm         = instr_i[IMM_BIT];
  assign rd          = instr_i[RD_HI:RD_LO];
  assign rs1         = instr_i[RS1_HI:RS1_LO];
  assign rs2         = instr_i[RS2_HI:RS2_LO];
  assign unused_bits = ^instr_i[RS2_LO-1:0];
  assign alu3        = (op <= OP_ASR) && (op != OP_NOT) && (op != OP_MOV);

  always_comb begin
    usage_o         = '0;
    usage_o.is_load = (op == OP_LD);

    case (op)
      OP_NOP, OP_CMP, OP_ST, OP_BEQ, OP_BGT, OP_B, OP_RET: usage_o.dst_valid = 1'b0;
      OP_CALL: begin
        usage_o.dst_valid = 1'b1;
        usage_o.dst       = RA;
      end
      default: begin
        usage_o.dst_valid = 1'b1;
        usage_o.dst       = rd;
      end
    endcase

    case (op)
      OP_NOP, OP_BEQ, OP_BGT, OP_B, OP_CALL, OP_NOT, OP_MOV: usage_o.src_valid[0] = 1'b0;
      OP_RET: begin
        usage_o.src_valid[0] = 1'b1;
        usage_o.src[0]       = RA;
      end
      default: begin
        usage_o.src_valid[0] = 1'b1;
        usage_o.src[0]       = rs1;
      end
    endcase

    if (!imm && (alu3 || op == OP_ST)) begin
      usage_o.src_valid[1] = 1'b1;
      usage_o.src[1]       = rs2;
    end

    // A store reads its rd field as the data to be written to memory.
    if (op == OP_ST) begin
      usage_o.src_valid[2] = 1'b1;
      usage_o.src[2]       = rd;
    end
  end

endmodule

// File: rtl/hazard_interlock.sv
// Stall/bubble interlock: tracks destinations of instructions in EX..RW and
// stalls the OF instruction when it reads one of them.
module hazard_interlock
  import pipe_pkg::*;
#(
  parameter bit FWD_EN = 1'b0,
  parameter int DEPTH  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] of_instr,
  input  logic        of_valid,
  input  logic        branch_taken,
  output logic        stall,
  output logic        bubble,
  output logic [15:0] busy_mask,
  output logic [15:0] stall_count
);

  usage_t           of_use;
  tag_t             tag_q [DEPTH];
  tag_t             tag_d [DEPTH];
  logic [DEPTH-1:0] hit;
  logic             hazard;
  logic [15:0]      stall_count_q, stall_count_d;

  instr_reg_usage u_usage (
    .instr_i (of_instr),
    .usage_o (of_use)
  );

  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int s = 0; s < 3; s++) begin
        if (tag_q[i].valid && of_use.src_valid[s] && (tag_q[i].rd == of_use.src[s]))
          hit[i] = 1'b1;
      end
    end
  end

  // With bypassing only a load still in EX cannot be forwarded in time.
  assign hazard = FWD_EN ? (hit[0] && tag_q[0].is_load) : (|hit);
  assign stall  = of_valid && hazard && !branch_taken;
  assign bubble = stall;

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tag_q[i].valid)
        busy_mask[tag_q[i].rd] = 1'b1;
    end
  end

  always_comb begin
    tag_d[0] = '0;
    if (of_valid && !stall && !branch_taken && of_use.dst_valid)
      tag_d[0] = tag_t'{valid: 1'b1, is_load: of_use.is_load, rd: of_use.dst};
    for (int i = 1; i < DEPTH; i++)
      tag_d[i] = tag_q[i-1];

    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 16'hFFFF))
      stall_count_d = stall_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        tag_q[i] <= '0;
      stall_count_q <= '0;
    end else begin
      tag_q         <= tag_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: doc/hazard_interlock.md
# hazard_interlock

Sequential interlock controller for the 5-stage pipeline (IF, OF, EX, MA, RW). It tracks destination registers of in-flight instructions downstream of OF and compares them against the sources of the instruction currently in OF. On a true dependence it holds IF and OF and injects bubbles into EX. It is the consumer-side counterpart of register-conflict detection: it turns detected dependences into stall and bubble control.

## Interface

Parameters:
- FWD_EN, default 0: 0 means no bypass network, so any pending write to a source stalls; 1 means bypass exists, so only load-use stalls.
- DEPTH, default 3: tracked stages after OF (EX, MA, RW).

Ports:
- clk, in, 1: clock. One clock domain; all state changes on the rising edge.
- rst, in, 1: reset. Synchronous and active-high.
- of_instr, in, 32: instruction in OF. Fields: opcode [31:27], imm [26], rd [25:22], rs1 [21:18], rs2 [17:14].
- of_valid, in, 1: of_instr holds a real instruction.
- branch_taken, in, 1: taken branch resolved in EX. Flushes IF and OF.
- stall, out, 1: hold PC and the IF/OF latch.
- bubble, out, 1: load NOP into the OF/EX latch.
- busy_mask, out, 16: bit n is 1 when a tracked stage will write rn.
- stall_count, out, 16: saturating count of stall cycles.

## Operation

- State is tag[0..DEPTH-1], each {valid, is_load, rd[3:0]}. tag[0] is EX and tag[DEPTH-1] is RW.
- Destination of the OF instruction:
  - none for nop, cmp, st, beq, bgt, b, ret;
  - r15 for call;
  - rd otherwise.
  - is_load = (opcode == ld).
- Sources of the OF instruction:
  - rs1 unless the opcode is nop, beq, bgt, b, call, not, mov;
  - r15 for ret;
  - rs2 when imm = 0 and the opcode is a 3-address ALU op (add..asr except not/mov) or st;
  - rd for st.
- hit(i) = tag[i].valid and tag[i].rd equals any valid source.
- hazard:
  - FWD_EN = 0: OR of hit(i) over all i.
  - FWD_EN = 1: hit(0) and tag[0].is_load.
- stall = bubble = of_valid and hazard and not branch_taken.
- Per-edge update:
  - tag[i] <= tag[i-1] for i ≥ 1.
  - tag[0] <= OF destination when of_valid, not stall, not branch_taken, and a destination exists; otherwise tag[0] is invalid.
- busy_mask is the OR of one-hot(tag[i].rd) over valid entries. It is combinational from state.
- stall_count increments on every cycle with stall = 1 and sticks at 16'hFFFF.
- Register file has no internal write-to-read bypass, so the RW entry participates in hazard checks.
- The block does not wrap around or drop entries: the shift register always advances, and stalls only freeze OF.

## Timing

- stall and bubble are combinational from of_instr, of_valid, branch_taken and tag state, with zero-cycle latency.
- FWD_EN = 0: a dependent instruction immediately after its producer stalls DEPTH cycles (3). With one independent instruction between them, it stalls 2.
- FWD_EN = 1: a load followed by a dependent instruction stalls exactly 1 cycle. All other dependences stall 0.
- Simultaneous events:
  - branch_taken with hazard: branch_taken wins. stall = 0, and no tag is inserted for the flushed OF instruction.
  - Stall cycle: the tags still shift and tag[0] gets an invalid entry, so the stall self-resolves.
- Reset:
  - Values on the edge with rst = 1: all tags invalid; busy_mask = 0; stall_count = 0; stall = bubble = 0 the following cycle.
  - rst overrides every other input, including mid-stall.

## Structure

- Shared package pipe_pkg holds:
  - opcode localparams (add 00000 … ret 10100, ld 01110, st 01111, call 10011);
  - field bit positions;
  - RA = 4'hF;
  - the tag record type and a NOP encoding (01101 << 27).
- One sub-module, instr_reg_usage: a combinational decode of a 32-bit instruction into {dst_valid, dst, is_load, src_valid[2:0], src[2:0]}. The writeback and bypass logic reuse it.
- The top holds the tag shift register, compare logic, counter and outputs.

## Test plan

1. FWD_EN = 0, add r1,r2,r3 then add r4,r1,r5 back-to-back: stall/bubble high 3 cycles, stall_count = 3, busy_mask bit 1 high for 3 cycles.
2. FWD_EN = 1, ld r1,[r2] then add r4,r1,r5: stall exactly 1 cycle. The same sequence with add in place of ld gives 0 stall cycles.
3. FWD_EN = 0, call then ret: ret stalls 3 cycles on r15, and busy_mask = 16'h8000 during the call's EX cycle.
4. cmp r1,r2 then beq; st r3,[r4] then add r5,r3,r6: no stall. add r7,… then st r7,[r0]: stall 3 cycles.
5. Assert branch_taken on the second stall cycle of scenario 1: stall drops that cycle, tag[0] is invalid next cycle, and stall_count = 1.
6. Assert rst mid-stall, then run a no-hazard stream: next cycle busy_mask = 0, stall = 0, stall_count = 0. Separately, force 65540 stall cycles: stall_count holds at 16'hFFFF.
